// File: rtl/multicycle_controller_if.sv
// ============================================================================
// Module : multicycle_controller_if
// Brief  : Controller <-> datapath bundle: decode inputs and control outputs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface multicycle_controller_if;
    logic [3:0] Op;
    logic [8:0] Func;
    logic       Zero;

    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       A3Src;
    logic       PCWrite;
    logic       OldPCWrite;
    logic       MDRWrite;
    logic       ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [1:0] PCSrc;
    logic [2:0] ALUControl;
    logic       Halted;

    modport master (
        input  Op, Func, Zero,
        output AdrSrc, MemWrite, IRWrite, RegWrite, A3Src, PCWrite, OldPCWrite,
               MDRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, PCSrc, ALUControl,
               Halted
    );

    modport slave (
        output Op, Func, Zero,
        input  AdrSrc, MemWrite, IRWrite, RegWrite, A3Src, PCWrite, OldPCWrite,
               MDRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, PCSrc, ALUControl,
               Halted
    );
endinterface

`default_nettype wire

// File: rtl/multicycle_controller.sv
// ============================================================================
// Module : multicycle_controller
// Brief  : Moore FSM control unit for a multicycle CPU. Optional macro
//          MC_ILLEGAL_TRAP_EN makes illegal Op/Func trap into a HALT state.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_controller (
    input  wire                     clk,
    input  wire                     reset,
    multicycle_controller_if.master io_ctl
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEM_RD = 4'd2,
        S_LD_WB  = 4'd3,
        S_MEM_WR = 4'd4,
        S_JMP    = 4'd5,
        S_BRZ    = 4'd6,
        S_C_EXEC = 4'd7,
        S_C_WB   = 4'd8,
        S_I_EXEC = 4'd9,
        S_I_WB   = 4'd10,
        S_HALT   = 4'd11
    } state_t;

    localparam logic [2:0] c_ALU_ADD   = 3'b000;
    localparam logic [2:0] c_ALU_SUB   = 3'b001;
    localparam logic [2:0] c_ALU_AND   = 3'b010;
    localparam logic [2:0] c_ALU_OR    = 3'b011;
    localparam logic [2:0] c_ALU_NOT   = 3'b100;
    localparam logic [2:0] c_ALU_PASSA = 3'b110;
    localparam logic [2:0] c_ALU_PASSB = 3'b111;

`ifdef MC_ILLEGAL_TRAP_EN
    localparam state_t c_ILLEGAL_NEXT = S_HALT;
`else
    localparam state_t c_ILLEGAL_NEXT = S_FETCH;
`endif

    state_t     r_state;
    state_t     w_next;

    logic       w_adr, w_mw, w_irw, w_rw, w_a3, w_pcw, w_opw, w_mdr, w_rs;
    logic [1:0] w_sa, w_sb, w_imm, w_pcs;
    logic [2:0] w_alu;

    logic       w_c_legal;
    logic [1:0] w_c_sa, w_c_sb;
    logic [2:0] w_c_alu;
    logic       w_c_a3;
    logic [2:0] w_i_alu;
    logic [1:0] w_i_imm;

    // Type-C Func must be exactly one-hot within bits [7:0] with bit 8 clear.
    assign w_c_legal = ~io_ctl.Func[8] && (io_ctl.Func[7:0] != 8'd0) &&
                       ((io_ctl.Func[7:0] & (io_ctl.Func[7:0] - 8'd1)) == 8'd0);

    always_comb begin
        w_c_sa  = 2'b00;
        w_c_sb  = 2'b00;
        w_c_alu = c_ALU_ADD;
        w_c_a3  = 1'b0;
        if (io_ctl.Func[0]) begin
            w_c_sa  = 2'b10;
            w_c_alu = c_ALU_PASSA;
            w_c_a3  = 1'b1;
        end else if (io_ctl.Func[1]) begin
            w_c_alu = c_ALU_PASSB;
        end else if (io_ctl.Func[2]) begin
            w_c_sa  = 2'b10;
            w_c_alu = c_ALU_ADD;
        end else if (io_ctl.Func[3]) begin
            w_c_sa  = 2'b10;
            w_c_alu = c_ALU_SUB;
        end else if (io_ctl.Func[4]) begin
            w_c_sa  = 2'b10;
            w_c_alu = c_ALU_AND;
        end else if (io_ctl.Func[5]) begin
            w_c_sa  = 2'b10;
            w_c_alu = c_ALU_OR;
        end else if (io_ctl.Func[6]) begin
            w_c_sa  = 2'b10;
            w_c_alu = c_ALU_NOT;
        end
    end

    // Immediate ops 11xx: low Op bits map directly onto add/sub/and/or.
    assign w_i_alu = {1'b0, io_ctl.Op[1:0]};
    assign w_i_imm = {1'b0, io_ctl.Op[1]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_adr  = 1'b0;
        w_mw   = 1'b0;
        w_irw  = 1'b0;
        w_rw   = 1'b0;
        w_a3   = 1'b0;
        w_pcw  = 1'b0;
        w_opw  = 1'b0;
        w_mdr  = 1'b0;
        w_rs   = 1'b0;
        w_sa   = 2'b00;
        w_sb   = 2'b00;
        w_imm  = 2'b00;
        w_pcs  = 2'b00;
        w_alu  = c_ALU_ADD;
        case (r_state)
            S_FETCH: begin
                w_irw  = 1'b1;
                w_opw  = 1'b1;
                w_pcw  = 1'b1;
                w_sb   = 2'b01;
                w_next = S_DECODE;
            end
            S_DECODE: begin
                case (io_ctl.Op)
                    4'b0000: w_next = S_MEM_RD;
                    4'b0001: w_next = S_MEM_WR;
                    4'b0010: w_next = S_JMP;
                    4'b0100: w_next = S_BRZ;
                    4'b1000: begin
                        if (!w_c_legal)          w_next = c_ILLEGAL_NEXT;
                        else if (io_ctl.Func[7]) w_next = S_FETCH;
                        else                     w_next = S_C_EXEC;
                    end
                    4'b1100, 4'b1101, 4'b1110, 4'b1111: w_next = S_I_EXEC;
                    default: w_next = c_ILLEGAL_NEXT;
                endcase
            end
            S_MEM_RD: begin
                w_adr  = 1'b1;
                w_mdr  = 1'b1;
                w_next = S_LD_WB;
            end
            S_LD_WB: begin
                w_rw   = 1'b1;
                w_rs   = 1'b1;
                w_next = S_FETCH;
            end
            S_MEM_WR: begin
                w_adr  = 1'b1;
                w_mw   = 1'b1;
                w_next = S_FETCH;
            end
            S_JMP: begin
                w_pcw  = 1'b1;
                w_pcs  = 2'b01;
                w_next = S_FETCH;
            end
            S_BRZ: begin
                w_sa   = 2'b10;
                w_alu  = c_ALU_PASSA;
                w_pcs  = 2'b10;
                w_pcw  = io_ctl.Zero;
                w_next = S_FETCH;
            end
            S_C_EXEC, S_C_WB: begin
                w_sa   = w_c_sa;
                w_sb   = w_c_sb;
                w_alu  = w_c_alu;
                w_a3   = w_c_a3;
                w_rw   = (r_state == S_C_WB);
                w_next = (r_state == S_C_EXEC) ? S_C_WB : S_FETCH;
            end
            S_I_EXEC, S_I_WB: begin
                w_sa   = 2'b10;
                w_sb   = 2'b10;
                w_alu  = w_i_alu;
                w_imm  = w_i_imm;
                w_rw   = (r_state == S_I_WB);
                w_next = (r_state == S_I_EXEC) ? S_I_WB : S_FETCH;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Strobes are gated by reset so they drop the instant reset asserts.
    assign io_ctl.IRWrite    = w_irw & reset;
    assign io_ctl.OldPCWrite = w_opw & reset;
    assign io_ctl.PCWrite    = w_pcw & reset;
    assign io_ctl.RegWrite   = w_rw  & reset;
    assign io_ctl.MemWrite   = w_mw  & reset;
    assign io_ctl.MDRWrite   = w_mdr & reset;

    assign io_ctl.AdrSrc     = w_adr;
    assign io_ctl.A3Src      = w_a3;
    assign io_ctl.ResultSrc  = w_rs;
    assign io_ctl.ALUSrcA    = w_sa;
    assign io_ctl.ALUSrcB    = w_sb;
    assign io_ctl.ImmSrc     = w_imm;
    assign io_ctl.PCSrc      = w_pcs;
    assign io_ctl.ALUControl = w_alu;

`ifdef MC_ILLEGAL_TRAP_EN
    assign io_ctl.Halted = (r_state == S_HALT) & reset;
`else
    assign io_ctl.Halted = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ============================================================================
// Module : tb_multicycle_controller
// Brief  : Scoreboard bench: stimulus pushes per-cycle expected control words,
//          a negedge monitor pops and compares. Honours MC_ILLEGAL_TRAP_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multicycle_controller;

    logic clk;
    logic reset;

    multicycle_controller_if bus();

    multicycle_controller dut (
        .clk    (clk),
        .reset  (reset),
        .io_ctl (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {adr,mw,irw,rw,a3,pcw,opw,mdr,rs,sa,sb,imm,pcs,alu,halted}
    function automatic logic [20:0] cv(input logic adr, input logic mw, input logic irw,
                                       input logic rw, input logic a3, input logic pcw,
                                       input logic opw, input logic mdr, input logic rs,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [1:0] imm, input logic [1:0] pcs,
                                       input logic [2:0] alu, input logic h);
        return {adr, mw, irw, rw, a3, pcw, opw, mdr, rs, sa, sb, imm, pcs, alu, h};
    endfunction

    logic [20:0] obs;
    assign obs = {bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.A3Src,
                  bus.PCWrite, bus.OldPCWrite, bus.MDRWrite, bus.ResultSrc,
                  bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.PCSrc, bus.ALUControl,
                  bus.Halted};

    logic [20:0] exp_q[$];
    string       nm_q[$];
    int          total  = 0;
    int          passed = 0;

    logic [20:0] V_F, V_D, V_RST, V_HALT;

    task automatic push(input string nm, input logic [20:0] v);
        exp_q.push_back(v);
        nm_q.push_back(nm);
    endtask

    // Drive an instruction at the start of FETCH and let it run n cycles.
    task automatic run(input logic [3:0] op, input logic [8:0] fn, input logic z, input int n);
        bus.Op   = op;
        bus.Func = fn;
        bus.Zero = z;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset(input string nm);
        reset = 1'b0;
        push(nm, V_RST);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic illegal(input string nm, input logic [3:0] op, input logic [8:0] fn);
        push({nm, "_fetch"}, V_F);
        push({nm, "_decode"}, V_D);
`ifdef MC_ILLEGAL_TRAP_EN
        for (int i = 0; i < 10; i++) push({nm, "_halt"}, V_HALT);
        run(op, fn, 1'b0, 12);
        pulse_reset({nm, "_reset_clears_halt"});
`else
        run(op, fn, 1'b0, 2);
`endif
    endtask

    initial begin : monitor
        logic [20:0] e;
        string       n;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = nm_q.pop_front();
                total++;
                if (obs === e) passed++;
                else $display("FAIL %s: got %h expected %h", n, obs, e);
            end
        end
    end

    initial begin : stim
        V_F    = cv(0,0,1,0,0,1,1,0,0, 2'b00,2'b01,2'b00,2'b00, 3'b000, 0);
        V_D    = cv(0,0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0);
        V_RST  = cv(0,0,0,0,0,0,0,0,0, 2'b00,2'b01,2'b00,2'b00, 3'b000, 0);
        V_HALT = cv(0,0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 1);

        reset    = 1'b0;
        bus.Op   = 4'h0;
        bus.Func = 9'h000;
        bus.Zero = 1'b0;
        @(posedge clk);
        #1;
        pulse_reset("reset_state");

        // LOAD 0x0123
        push("ld_fetch", V_F);
        push("ld_decode", V_D);
        push("ld_memrd", cv(1,0,0,0,0,0,0,1,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0));
        push("ld_wb",    cv(0,0,0,1,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0));
        run(4'h0, 9'h123, 1'b0, 4);

        // STORE
        push("st_fetch", V_F);
        push("st_decode", V_D);
        push("st_memwr", cv(1,1,0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0));
        run(4'h1, 9'h000, 1'b0, 3);

        // JUMP
        push("jmp_fetch", V_F);
        push("jmp_decode", V_D);
        push("jmp_exec", cv(0,0,0,0,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b01, 3'b000, 0));
        run(4'h2, 9'h000, 1'b0, 3);

        // BRZ 0x4005, taken and not taken
        push("brz1_fetch", V_F);
        push("brz1_decode", V_D);
        push("brz1_taken", cv(0,0,0,0,0,1,0,0,0, 2'b10,2'b00,2'b00,2'b10, 3'b110, 0));
        run(4'h4, 9'h005, 1'b1, 3);
        push("brz0_fetch", V_F);
        push("brz0_decode", V_D);
        push("brz0_not_taken", cv(0,0,0,0,0,0,0,0,0, 2'b10,2'b00,2'b00,2'b10, 3'b110, 0));
        run(4'h4, 9'h005, 1'b0, 3);

        // Type-C MoveFrom 0x8602
        push("mvf_fetch", V_F);
        push("mvf_decode", V_D);
        push("mvf_exec", cv(0,0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b111, 0));
        push("mvf_wb",   cv(0,0,0,1,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b111, 0));
        run(4'h8, 9'h002, 1'b0, 4);

        // Type-C MoveTo
        push("mvt_fetch", V_F);
        push("mvt_decode", V_D);
        push("mvt_exec", cv(0,0,0,0,1,0,0,0,0, 2'b10,2'b00,2'b00,2'b00, 3'b110, 0));
        push("mvt_wb",   cv(0,0,0,1,1,0,0,0,0, 2'b10,2'b00,2'b00,2'b00, 3'b110, 0));
        run(4'h8, 9'h001, 1'b0, 4);

        // Type-C sub
        push("csub_fetch", V_F);
        push("csub_decode", V_D);
        push("csub_exec", cv(0,0,0,0,0,0,0,0,0, 2'b10,2'b00,2'b00,2'b00, 3'b001, 0));
        push("csub_wb",   cv(0,0,0,1,0,0,0,0,0, 2'b10,2'b00,2'b00,2'b00, 3'b001, 0));
        run(4'h8, 9'h008, 1'b0, 4);

        // Type-C not
        push("cnot_fetch", V_F);
        push("cnot_decode", V_D);
        push("cnot_exec", cv(0,0,0,0,0,0,0,0,0, 2'b10,2'b00,2'b00,2'b00, 3'b100, 0));
        push("cnot_wb",   cv(0,0,0,1,0,0,0,0,0, 2'b10,2'b00,2'b00,2'b00, 3'b100, 0));
        run(4'h8, 9'h040, 1'b0, 4);

        // Type-C nop: two cycles
        push("nop_fetch", V_F);
        push("nop_decode", V_D);
        run(4'h8, 9'h080, 1'b0, 2);

        // andi 0xE0FF
        push("andi_fetch", V_F);
        push("andi_decode", V_D);
        push("andi_exec", cv(0,0,0,0,0,0,0,0,0, 2'b10,2'b10,2'b01,2'b00, 3'b010, 0));
        push("andi_wb",   cv(0,0,0,1,0,0,0,0,0, 2'b10,2'b10,2'b01,2'b00, 3'b010, 0));
        run(4'hE, 9'h0FF, 1'b0, 4);

        // addi
        push("addi_fetch", V_F);
        push("addi_decode", V_D);
        push("addi_exec", cv(0,0,0,0,0,0,0,0,0, 2'b10,2'b10,2'b00,2'b00, 3'b000, 0));
        push("addi_wb",   cv(0,0,0,1,0,0,0,0,0, 2'b10,2'b10,2'b00,2'b00, 3'b000, 0));
        run(4'hC, 9'h001, 1'b0, 4);

        illegal("ill_func_multi", 4'h8, 9'h003);
        illegal("ill_func_bit8",  4'h8, 9'h100);
        illegal("ill_op_0111",    4'h7, 9'h000);

        // Reset dropped in the middle of MEM_WR, then a LOAD after release
        push("rst_st_fetch", V_F);
        push("rst_st_decode", V_D);
        run(4'h1, 9'h000, 1'b0, 2);
        #2;
        reset = 1'b0;
        push("rst_during_memwr", V_RST);
        @(posedge clk);
        #1;
        reset = 1'b1;
        push("post_rst_fetch", V_F);
        push("post_rst_decode", V_D);
        push("post_rst_memrd", cv(1,0,0,0,0,0,0,1,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0));
        push("post_rst_ldwb",  cv(0,0,0,1,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0));
        run(4'h0, 9'h123, 1'b0, 4);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            total++;
            $display("FAIL drain: %0d expected words left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named as follows.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
REQ-002 Inputs from the datapath SHALL be:
- Op  in  4  Instr[15:12].
- Func  in  9  Instr[8:0].
- Zero  in  1  combinational ALU zero flag.
REQ-003 Control outputs SHALL be:
- AdrSrc, MemWrite, IRWrite, RegWrite, A3Src, PCWrite, OldPCWrite, MDRWrite, ResultSrc  out  1 each.
- ALUSrcA, ALUSrcB, ImmSrc, PCSrc  out  2 each.
- ALUControl  out  3.
REQ-004 Status output SHALL be: Halted  out  1  trap indicator (see Configuration).

Function
REQ-005 The block SHALL be a Moore FSM; outputs SHALL decode from state only, except PCWrite in BRZ, which also depends on Zero.
REQ-006 Outputs not listed for a state SHALL be 0.
REQ-007 ALUControl encodings SHALL be: 000 add, 001 sub, 010 and, 011 or, 100 not In1, 110 pass In1, 111 pass In2.
REQ-008 Source selects SHALL be:
- ALUSrcA: 00 PC, 01 OldPC, 10 A.
- ALUSrcB: 00 B, 01 constant 1, 10 ImmExt.
- PCSrc: 00 ALU, 01 jump, 10 branch.
- ImmSrc: 00 sign-extend Instr[11:0], 01 zero-extend Instr[11:0].
REQ-009 FETCH SHALL assert IRWrite=1, OldPCWrite=1, PCWrite=1, ALUSrcB=01, with ALUSrcA=00, ALUControl=000, PCSrc=00, AdrSrc=0; next state DECODE.
REQ-010 DECODE SHALL assert no strobes, and SHALL branch on Op:
- 0000 LOAD -> MEM_RD.
- 0001 STORE -> MEM_WR.
- 0010 JUMP -> JMP.
- 0100 BRZ -> BRZ.
- 1000 type-C -> C_EXEC.
- 1100/1101/1110/1111 (addi/subi/andi/ori) -> I_EXEC.
- any other Op -> illegal.
REQ-011 MEM_RD SHALL assert AdrSrc=1, MDRWrite=1 -> LD_WB; LD_WB SHALL assert RegWrite=1, ResultSrc=1, A3Src=0 -> FETCH.
REQ-012 MEM_WR SHALL assert AdrSrc=1, MemWrite=1 -> FETCH.
REQ-013 JMP SHALL assert PCWrite=1, PCSrc=01 -> FETCH.
REQ-014 BRZ SHALL assert ALUSrcA=10, ALUControl=110, PCSrc=10, PCWrite=Zero -> FETCH.
REQ-015 Type-C Func SHALL be one-hot:
- bit0 MoveTo: ALUSrcA=10, ALUControl=110, A3Src=1.
- bit1 MoveFrom: ALUSrcB=00, ALUControl=111.
- bit2 add, bit3 sub, bit4 and, bit5 or: ALUSrcA=10, ALUSrcB=00.
- bit6 not: ALUSrcA=10, ALUControl=100.
- bit7 nop: DECODE -> FETCH directly.
- zero or multiple bits set, or bit8 set -> illegal.
REQ-016 C_EXEC SHALL drive the selects from REQ-015 -> C_WB; C_WB SHALL assert RegWrite=1, ResultSrc=0, A3Src per REQ-015 -> FETCH.
REQ-017 I_EXEC SHALL drive ALUSrcA=10, ALUSrcB=10, ALUControl = add/sub/and/or for Op 1100/1101/1110/1111, and ImmSrc=00 for addi/subi, 01 for andi/ori -> I_WB; I_WB SHALL assert RegWrite=1, A3Src=0 -> FETCH.
REQ-018 Instruction latency SHALL be: LOAD/C/I 4 cycles, STORE/JMP/BRZ 3 cycles, nop 2 cycles.
REQ-019 The select values of REQ-015/017 SHALL remain stable in the WB state (Func/Op are held by IR).

Reset
REQ-020 While reset=0, state SHALL be FETCH and every write strobe (IRWrite, OldPCWrite, PCWrite, RegWrite, MemWrite, MDRWrite) SHALL be forced to 0; Halted SHALL be 0.
REQ-021 The first FETCH strobes SHALL occur on the first rising edge after reset deasserts.
REQ-022 Reset asserted mid-instruction SHALL abort it immediately with no further strobes.

Configuration
REQ-023 Macro MC_ILLEGAL_TRAP_EN:
- Defined: illegal Op/Func SHALL enter HALT, which has all strobes 0 and Halted=1, and which only reset leaves.
- Undefined: illegal SHALL go DECODE -> FETCH (NOP) and Halted SHALL be tied 0.

Verification
REQ-024 LOAD 0x0123 (instr 16'h0123): strobes follow FETCH, DECODE, MEM_RD (AdrSrc=1, MDRWrite=1), LD_WB (RegWrite=1, ResultSrc=1); total 4 cycles.
REQ-025 BRZ 16'h4005 with Zero=1 -> PCWrite=1, PCSrc=10 in BRZ; with Zero=0 -> PCWrite=0; both take 3 cycles.
REQ-026 Type-C 16'h8602 (Func=000000010, MoveFrom): C_EXEC has ALUControl=111, ALUSrcB=00; C_WB has RegWrite=1, A3Src=0. Func=000000011 -> illegal.
REQ-027 andi 16'hE0FF: I_EXEC has ImmSrc=01, ALUControl=010, ALUSrcB=10; I_WB has RegWrite=1.
REQ-028 Op=0111 with macro -> Halted=1 persists 10+ cycles with no strobes, cleared by reset; without macro -> FETCH after 2 cycles.
REQ-029 Reset pulled low during MEM_WR -> MemWrite drops to 0 asynchronously; after release, FETCH occurs.
